// File: rtl/inv_sub_bytes_engine.sv
// Iterative AES InvSubBytes engine: substitutes BYTES_PER_CYCLE bytes of a
// 128-bit state per clock through the FIPS-197 inverse S-box.
module inv_sub_bytes_engine #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_PASSES = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NUM_PASSES - 1);

  // Entry 0 is the leftmost byte: INV_SBOX[x] = InvS(x).
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_illegal_bpc
      $error("inv_sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       work;
  logic [3:0]         lane [BYTES_PER_CYCLE];
  logic [7:0]         sub  [BYTES_PER_CYCLE];

  // Each read port looks up one byte of the current pass, LSB byte first.
  always_comb begin
    for (int p = 0; p < BYTES_PER_CYCLE; p++) begin
      lane[p] = 4'(int'(cnt) * BYTES_PER_CYCLE + p);
      sub[p]  = INV_SBOX[work[{lane[p], 3'b000} +: 8]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the handshake outputs are registered alongside
  // the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            cnt      <= '0;
            state    <= BUSY;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        BUSY: begin
          for (int p = 0; p < BYTES_PER_CYCLE; p++) begin
            work[{lane[p], 3'b000} +: 8] <= sub[p];
          end
          if (cnt == LAST_PASS) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE here means no new state is taken on the handshake edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed bench for inv_sub_bytes_engine: three instances (4, 1 and 16 bytes
// per cycle) share stimulus; references come from an S-box derived in the bench
// from GF(2^8) arithmetic.
module tb_inv_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic [2:0]   ov, ir, bz;
  logic [127:0] od [3];

  int checks = 0;
  int errors = 0;
  int lat [3] = '{4, 16, 1};

  logic [7:0] fwd [256];
  logic [7:0] inv_ref [256];

  always #5 clk = ~clk;

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1)) dut_bpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(16)) dut_bpc16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

  // Forward S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_ref[s[8*i +: 8]];
    return r;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      fwd[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_ref[fwd[x]] = 8'(x);
  endtask

  task automatic wait_all_idle();
    int n = 0;
    while (ir !== 3'b111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%b required 111", ir);
    end
  endtask

  // One transaction: accept, measure latency per instance, compare data, handshake out.
  task automatic run_state(input logic [127:0] data, input logic [127:0] exp, input string name);
    int first [3];
    wait_all_idle();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 3; i++) first[i] = -1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (first[i] < 0 && ov[i] === 1'b1) first[i] = j;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] !== lat[i]) begin
        errors++;
        $display("FAIL %s latency inst%0d: got %0d required %0d", name, i, first[i], lat[i]);
      end
      checks++;
      if (od[i] !== exp) begin
        errors++;
        $display("FAIL %s data inst%0d: got %h required %h", name, i, od[i], exp);
      end
      checks++;
      if (fwd_state(od[i]) !== data) begin
        errors++;
        $display("FAIL %s roundtrip inst%0d: got %h required %h", name, i, fwd_state(od[i]), data);
      end
      checks++;
      if ({ov[i], ir[i], bz[i]} !== 3'b101) begin
        errors++;
        $display("FAIL %s done_flags inst%0d: got %b required 101", name, i, {ov[i], ir[i], bz[i]});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({ov, ir, bz} !== 9'b000_111_000) begin
      errors++;
      $display("FAIL %s handshake: got ov=%b ir=%b bz=%b required 000 111 000", name, ov, ir, bz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ov[i], bz[i]} !== 2'b00 || od[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset inst%0d: got ov=%b bz=%b od=%h required 0 0 0", i, ov[i], bz[i], od[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 111", ir);
    end
  endtask

  task automatic test_directed();
    run_state(128'hFA9EBF01, 128'h52525252_52525252_52525252_14DFF409, "vec1");
    run_state({16{8'h63}}, 128'h0, "all63");
    run_state({16{8'h16}}, {16{8'hFF}}, "all16");
    run_state(128'h7C526316, 128'h52525252_52525252_52525252_014800FF, "mixed");
  endtask

  task automatic test_exhaustive();
    for (int s = 0; s < 16; s++) begin
      logic [127:0] d;
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * s + i);
      run_state(d, inv_state(d), $sformatf("exh%0d", s));
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp = 128'h52525252_52525252_52525252_14DFF409;
    int n = 0;
    wait_all_idle();
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'hFA9EBF01;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    while (ov !== 3'b111 && n < 30) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (od[i] !== exp || {ov[i], ir[i]} !== 2'b10) begin
          errors++;
          $display("FAIL backpressure cyc%0d inst%0d: got ov=%b ir=%b od=%h required 1 0 %h",
                   k, i, ov[i], ir[i], od[i], exp);
        end
      end
      in_valid = (k % 2) == 0;
      in_data  = ~exp;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({ov, ir} !== 6'b000_111) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b ir=%b required 000 111", ov, ir);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bz !== 3'b000) begin
      errors++;
      $display("FAIL backpressure_not_queued: busy=%b required 000", bz);
    end
  endtask

  // in_valid and out_ready held high: each instance cycles BUSY(N) -> DONE(1) -> IDLE(1).
  task automatic test_back_to_back();
    logic [127:0] exp = 128'h52525252_52525252_52525252_14DFF409;
    wait_all_idle();
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'hFA9EBF01; out_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int q = j % (lat[i] + 2);
        logic [2:0] want;
        if (q < lat[i])       want = 3'b001;
        else if (q == lat[i]) want = 3'b101;
        else                  want = 3'b010;
        checks++;
        if ({ov[i], ir[i], bz[i]} !== want) begin
          errors++;
          $display("FAIL b2b cyc%0d inst%0d: got ov/ir/bz=%b required %b", j, i, {ov[i], ir[i], bz[i]}, want);
        end
        if (q == lat[i]) begin
          checks++;
          if (od[i] !== exp) begin
            errors++;
            $display("FAIL b2b data cyc%0d inst%0d: got %h required %h", j, i, od[i], exp);
          end
        end
      end
    end
    in_valid = 1'b0; in_data = '0;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int pulses = 0;
    wait_all_idle();
    @(negedge clk);
    in_valid = 1'b1; in_data = {16{8'h16}};
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ov[i], bz[i]} !== 2'b00 || od[i] !== 128'h0) begin
        errors++;
        $display("FAIL midreset inst%0d: got ov=%b bz=%b od=%h required 0 0 0", i, ov[i], bz[i], od[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ov !== 3'b000) pulses++;
    end
    checks++;
    if (pulses != 0 || ir !== 3'b111) begin
      errors++;
      $display("FAIL midreset_after: valid cycles=%0d ir=%b required 0 111", pulses, ir);
    end
    run_state(128'hFA9EBF01, 128'h52525252_52525252_52525252_14DFF409, "post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
